// File: rtl/torect_pkg.sv
// torect_pkg: shared constants, types and helpers for the polar-to-rectangular
// CORDIC (torect).
//   ZW       internal phase width; 2^ZW units = one full circle
//   ATAN     per-iteration rotation angles in ZW units
//   KINV     inverse CORDIC gain (x256), indexed by the number of iterations
//   state_e  FSM state encoding
//   sat_sym  symmetric saturation to +/-(2^(ow-1)-1)
package torect_pkg;

    localparam int ZW = 8;

    localparam logic [ZW-1:0] ATAN [0:5] = '{8'd32, 8'd19, 8'd10, 8'd5, 8'd3, 8'd1};

    localparam logic [7:0] KINV [1:6] = '{8'd181, 8'd162, 8'd157, 8'd156, 8'd156, 8'd155};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ROT  = 2'd1,
        ST_OUT  = 2'd2
    } state_e;

    // Clamp v to the symmetric range of an ow-bit signed result; the most
    // negative code is never produced so X/Y stay sign-symmetric.
    function automatic int sat_sym(input int v, input int ow);
        int lim;
        lim = (1 << (ow - 1)) - 1;
        if (v > lim) begin
            return lim;
        end
        if (v < -lim) begin
            return -lim;
        end
        return v;
    endfunction

endpackage

// File: rtl/torect_if.sv
// torect_if: request/result bundle of the polar-to-rectangular converter.
//   i_start      request a conversion (accepted only while the core is idle)
//   i_mag        unsigned magnitude, MW bits
//   i_phase      unsigned binary angle, PW bits (2^PW = full circle)
//   o_busy       core is converting
//   o_done       one-enabled-cycle pulse: o_xval/o_yval just updated
//   o_xval/yval  signed OW-bit results, held until the next o_done
//   o_dbg_state  current FSM state (torect_pkg::state_e encoding)
//
// Handshake: a request is taken on an enabled clock edge where i_start=1 and
// o_busy=0; i_mag/i_phase are sampled on that same edge. Requests while busy
// are dropped, not queued. o_done marks the single enabled cycle where new
// results appear; a new request may be issued in that very cycle.
interface torect_if #(
    parameter int MW = 6,
    parameter int PW = 4,
    parameter int OW = 7
);
    logic                 i_start;
    logic [MW-1:0]        i_mag;
    logic [PW-1:0]        i_phase;
    logic                 o_busy;
    logic                 o_done;
    logic signed [OW-1:0] o_xval;
    logic signed [OW-1:0] o_yval;
    logic [1:0]           o_dbg_state;

    modport master (
        output i_start, i_mag, i_phase,
        input  o_busy, o_done, o_xval, o_yval, o_dbg_state
    );

    modport slave (
        input  i_start, i_mag, i_phase,
        output o_busy, o_done, o_xval, o_yval, o_dbg_state
    );
endinterface

// File: rtl/torect.sv
// torect: iterative rotation-mode CORDIC turning (magnitude, phase) into
// signed (X, Y). One micro-rotation per enabled clock; a conversion takes
// NSTAGES+2 enabled cycles (load, NSTAGES rotations, output).
//   i_clk    clock
//   i_reset  synchronous active-high reset; aborts a conversion in flight
//   i_ce     clock enable; when low every register holds, including o_done
//   bus      torect_if.slave request/result bundle
module torect
    import torect_pkg::*;
#(
    parameter int MW      = 6,
    parameter int PW      = 4,
    parameter int OW      = 7,
    parameter int NSTAGES = 4
) (
    input  logic     i_clk,
    input  logic     i_reset,
    input  logic     i_ce,
    torect_if.slave  bus
);

    localparam int WW = OW + 2;
    localparam int KW = 3;

    state_e               state_q, state_d;
    logic signed [WW-1:0] x_q, x_d;
    logic signed [WW-1:0] y_q, y_d;
    logic signed [ZW-1:0] z_q, z_d;
    logic [KW-1:0]        k_q, k_d;
    logic                 done_q, done_d;
    logic signed [OW-1:0] xval_q, xval_d;
    logic signed [OW-1:0] yval_q, yval_d;

    logic signed [WW-1:0] m;
    logic [ZW-1:0]        z0;
    logic [1:0]           q;
    logic signed [WW-1:0] x_sh, y_sh;
    logic [ZW-1:0]        atan_k;

    always_comb begin
        // Pre-scale by 1/K so the rotated vector comes out at ~i_mag.
        m      = WW'((32'(bus.i_mag) * 32'(KINV[NSTAGES])) >> 8);
        z0     = {bus.i_phase, {(ZW-PW){1'b0}}};
        // Nearest quarter turn: round z0 by an eighth turn, keep the top two bits.
        q      = 2'((z0 + ZW'(32)) >> (ZW - 2));
        x_sh   = x_q >>> k_q;
        y_sh   = y_q >>> k_q;
        atan_k = ATAN[k_q];

        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        k_d     = k_q;
        done_d  = done_q;
        xval_d  = xval_q;
        yval_d  = yval_q;

        if (i_ce) begin
            done_d = 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.i_start) begin
                        // Residual stays within [-1/8, 1/8) turn after the
                        // quarter-turn pre-rotation.
                        z_d = z0 - {q, {(ZW-2){1'b0}}};
                        case (q)
                            2'd0: begin x_d = m;     y_d = '0;    end
                            2'd1: begin x_d = '0;    y_d = m;     end
                            2'd2: begin x_d = -m;    y_d = '0;    end
                            default: begin x_d = '0; y_d = -m;    end
                        endcase
                        k_d     = '0;
                        state_d = ST_ROT;
                    end
                end
                ST_ROT: begin
                    if (!z_q[ZW-1]) begin
                        x_d = x_q - y_sh;
                        y_d = y_q + x_sh;
                        z_d = z_q - $signed(atan_k);
                    end else begin
                        x_d = x_q + y_sh;
                        y_d = y_q - x_sh;
                        z_d = z_q + $signed(atan_k);
                    end
                    k_d = k_q + 1'b1;
                    if (k_q == KW'(NSTAGES - 1)) begin
                        state_d = ST_OUT;
                    end
                end
                ST_OUT: begin
                    xval_d  = OW'(sat_sym(int'(x_q), OW));
                    yval_d  = OW'(sat_sym(int'(y_q), OW));
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            k_q     <= '0;
            done_q  <= 1'b0;
            xval_q  <= '0;
            yval_q  <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            k_q     <= k_d;
            done_q  <= done_d;
            xval_q  <= xval_d;
            yval_q  <= yval_d;
        end
    end

    assign bus.o_busy      = (state_q != ST_IDLE);
    assign bus.o_done      = done_q;
    assign bus.o_xval      = xval_q;
    assign bus.o_yval      = yval_q;
    assign bus.o_dbg_state = state_q;

endmodule

// File: tb/tb_torect.sv
// tb_torect: directed bench for the torect polar-to-rectangular CORDIC.
module tb_torect;

    localparam int MW  = 6;
    localparam int PW  = 4;
    localparam int OW  = 7;
    localparam int NST = 4;

    logic clk = 1'b0;
    logic rst;
    logic ce;

    always #5 clk = ~clk;

    torect_if #(.MW(MW), .PW(PW), .OW(OW)) bus();

    torect #(.MW(MW), .PW(PW), .OW(OW), .NSTAGES(NST)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .i_ce    (ce),
        .bus     (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Bit-true reference: gain 156/256, quarter-turn pre-rotation, four
    // micro-rotations with arithmetic-shift floor, symmetric saturation.
    function automatic void model(input int mag, input int ph, output int xo, output int yo);
        int at [4];
        int m, z0, q, z, x, y, nx, ny;
        at = '{32, 19, 10, 5};
        m  = (mag * 156) / 256;
        z0 = ph * 16;
        q  = ((z0 + 32) / 64) % 4;
        z  = z0 - 64 * q;
        if (z >= 128) z = z - 256;
        case (q)
            0: begin x = m;  y = 0;  end
            1: begin x = 0;  y = m;  end
            2: begin x = -m; y = 0;  end
            default: begin x = 0; y = -m; end
        endcase
        for (int k = 0; k < 4; k++) begin
            if (z >= 0) begin
                nx = x - (y >>> k); ny = y + (x >>> k); z = z - at[k];
            end else begin
                nx = x + (y >>> k); ny = y - (x >>> k); z = z + at[k];
            end
            x = nx; y = ny;
        end
        xo = (x > 63) ? 63 : ((x < -63) ? -63 : x);
        yo = (y > 63) ? 63 : ((y < -63) ? -63 : y);
    endfunction

    // Issue one request and wait (bounded) for o_done. Enabled edges
    // stall_at+1 .. stall_at+stall_len after the load edge run with i_ce=0.
    task automatic run_conv(input int mag, input int ph, input int stall_at, input int stall_len,
                            output int lat, output int xo, output int yo, output bit got);
        ce          = 1'b1;
        bus.i_mag   = MW'(mag);
        bus.i_phase = PW'(ph);
        bus.i_start = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0;
        lat = 0; xo = 0; yo = 0; got = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            ce = !(c > stall_at && c <= stall_at + stall_len);
            @(negedge clk);
            if (bus.o_done === 1'b1) begin
                lat = c; xo = bus.o_xval; yo = bus.o_yval; got = 1'b1;
                break;
            end
        end
        ce = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; ce = 1'b1;
        bus.i_start = 1'b0; bus.i_mag = '0; bus.i_phase = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (bus.o_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %0b want 0", bus.o_busy); end
        n_cmp++; if (bus.o_done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %0b want 0", bus.o_done); end
        n_cmp++; if (bus.o_xval !== 7'sd0) begin n_bad++; $display("FAIL reset_xval: got %0d want 0", bus.o_xval); end
        n_cmp++; if (bus.o_yval !== 7'sd0) begin n_bad++; $display("FAIL reset_yval: got %0d want 0", bus.o_yval); end
        n_cmp++; if (bus.o_dbg_state !== 2'd0) begin n_bad++; $display("FAIL reset_state: got %0d want 0", bus.o_dbg_state); end
    endtask

    task automatic test_directed();
        int vec [8][4];
        int lat, xo, yo;
        bit got;
        // mag, phase, expected x, expected y (hand-traced through the algorithm)
        vec = '{'{63, 0, 61, -2}, '{63, 4, 2, 63}, '{63, 8, -63, 4}, '{63, 12, -4, -61},
                '{63, 15, 57, -27}, '{63, 2, 39, 49}, '{10, 0, 9, 0}, '{0, 5, 0, 0}};
        for (int i = 0; i < 8; i++) begin
            run_conv(vec[i][0], vec[i][1], 0, 0, lat, xo, yo, got);
            n_cmp++; if (!got) begin n_bad++; $display("FAIL dir_done[%0d]: no o_done within bound", i); end
            n_cmp++; if (lat != NST + 1) begin n_bad++; $display("FAIL dir_lat[%0d]: got %0d want %0d", i, lat, NST + 1); end
            n_cmp++; if (xo != vec[i][2]) begin n_bad++; $display("FAIL dir_x[%0d]: got %0d want %0d", i, xo, vec[i][2]); end
            n_cmp++; if (yo != vec[i][3]) begin n_bad++; $display("FAIL dir_y[%0d]: got %0d want %0d", i, yo, vec[i][3]); end
        end
    endtask

    task automatic test_sweep();
        int lat, xo, yo, ex, ey;
        bit got;
        real ang, dx, dy;
        for (int ph = 0; ph < 16; ph++) begin
            model(63, ph, ex, ey);
            run_conv(63, ph, 0, 0, lat, xo, yo, got);
            n_cmp++; if (!got || xo != ex || yo != ey) begin
                n_bad++; $display("FAIL sweep[%0d]: got (%0d,%0d) done=%0b want (%0d,%0d)", ph, xo, yo, got, ex, ey);
            end
            // Coarse sanity against the ideal circle point.
            ang = 2.0 * 3.14159265358979 * real'(ph) / 16.0;
            dx  = real'(xo) - 63.0 * $cos(ang); if (dx < 0.0) dx = -dx;
            dy  = real'(yo) - 63.0 * $sin(ang); if (dy < 0.0) dy = -dy;
            n_cmp++; if (dx > 8.0 || dy > 8.0) begin
                n_bad++; $display("FAIL sweep_err[%0d]: got (%0d,%0d) error (%f,%f) want <= 8", ph, xo, yo, dx, dy);
            end
        end
    endtask

    task automatic test_back_to_back();
        int ndone;
        bit exp_done;
        ndone = 0;
        ce = 1'b1;
        bus.i_mag = 6'd63; bus.i_phase = 4'd4; bus.i_start = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            exp_done = ((i % 6) == 5);
            if (bus.o_done === 1'b1) ndone++;
            n_cmp++; if (bus.o_done !== exp_done) begin n_bad++; $display("FAIL b2b_done[%0d]: got %0b want %0b", i, bus.o_done, exp_done); end
            n_cmp++; if (bus.o_busy !== !exp_done) begin n_bad++; $display("FAIL b2b_busy[%0d]: got %0b want %0b", i, bus.o_busy, !exp_done); end
            if (exp_done) begin
                n_cmp++; if (bus.o_xval !== 7'sd2 || bus.o_yval !== 7'sd63) begin
                    n_bad++; $display("FAIL b2b_xy[%0d]: got (%0d,%0d) want (2,63)", i, bus.o_xval, bus.o_yval);
                end
            end
        end
        bus.i_start = 1'b0;
        @(negedge clk);
        n_cmp++; if (ndone != 5) begin n_bad++; $display("FAIL b2b_count: got %0d want 5", ndone); end
        n_cmp++; if (bus.o_done !== 1'b0 || bus.o_busy !== 1'b0) begin
            n_bad++; $display("FAIL b2b_idle: got done=%0b busy=%0b want 0/0", bus.o_done, bus.o_busy);
        end
    endtask

    task automatic test_stall();
        int lat, xo, yo;
        bit got;
        run_conv(63, 2, 2, 3, lat, xo, yo, got);
        n_cmp++; if (!got || lat != NST + 1 + 3) begin n_bad++; $display("FAIL stall_lat: got %0d (done=%0b) want %0d", lat, got, NST + 4); end
        n_cmp++; if (xo != 39 || yo != 49) begin n_bad++; $display("FAIL stall_xy: got (%0d,%0d) want (39,49)", xo, yo); end
        // o_done must hold while the enable is low.
        ce = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if (bus.o_done !== 1'b1) begin n_bad++; $display("FAIL stall_done_hold: got %0b want 1", bus.o_done); end
        n_cmp++; if (bus.o_xval !== 7'sd39) begin n_bad++; $display("FAIL stall_x_hold: got %0d want 39", bus.o_xval); end
        ce = 1'b1;
        @(negedge clk);
        n_cmp++; if (bus.o_done !== 1'b0) begin n_bad++; $display("FAIL stall_done_clear: got %0b want 0", bus.o_done); end
    endtask

    task automatic test_reset_mid();
        int lat, xo, yo, spurious;
        bit got;
        ce = 1'b1;
        bus.i_mag = 6'd63; bus.i_phase = 4'd4; bus.i_start = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if (bus.o_dbg_state !== 2'd1) begin n_bad++; $display("FAIL midrst_pre_state: got %0d want 1", bus.o_dbg_state); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++; if (bus.o_busy !== 1'b0 || bus.o_dbg_state !== 2'd0) begin
            n_bad++; $display("FAIL midrst_state: got busy=%0b state=%0d want 0/0", bus.o_busy, bus.o_dbg_state);
        end
        n_cmp++; if (bus.o_xval !== 7'sd0 || bus.o_yval !== 7'sd0 || bus.o_done !== 1'b0) begin
            n_bad++; $display("FAIL midrst_out: got (%0d,%0d) done=%0b want (0,0) 0", bus.o_xval, bus.o_yval, bus.o_done);
        end
        spurious = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.o_done !== 1'b0) spurious++;
        end
        n_cmp++; if (spurious != 0) begin n_bad++; $display("FAIL midrst_no_done: got %0d pulses want 0", spurious); end
        run_conv(63, 0, 0, 0, lat, xo, yo, got);
        n_cmp++; if (!got || lat != NST + 1 || xo != 61 || yo != -2) begin
            n_bad++; $display("FAIL midrst_after: got lat=%0d (%0d,%0d) want lat=5 (61,-2)", lat, xo, yo);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_sweep();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
